// File: rtl/carrd_pkg.sv
// Shared constants and types for the vector writeback arbiter.
package carrd_pkg;

  localparam int N_SRC      = 5;
  localparam int VD_W       = 5;
  localparam int EL_W       = 4;
  localparam int LANE_W     = 128;
  localparam int N_LANES    = 4;
  localparam int SRC_DATA_W = N_LANES * LANE_W;
  localparam int SRC_IDX_W  = 3;
  localparam int RED_W      = 32;
  localparam int CNT_W      = 16;

  typedef enum logic [SRC_IDX_W-1:0] {
    SRC_VALU  = 3'd0,
    SRC_VMUL  = 3'd1,
    SRC_VLSU  = 3'd2,
    SRC_VSLDU = 3'd3,
    SRC_VRED  = 3'd4
  } src_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OUT  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/carrd_rr_arb.sv
// N-way round-robin grant; the search starts at ptr_q and the pointer moves
// past the winner only on an accepted transfer.
module carrd_rr_arb #(
  parameter int N     = 5,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [N-1:0]     req_i,
  input  logic             en_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] winner_o,
  output logic             fire_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;
  logic             found;

  // Scan from the farthest candidate back to ptr_q so the last hit is the
  // first valid index in round-robin order.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    sum      = '0;
    idx      = '0;
    found    = 1'b0;
    winner_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
      idx = sum[IDX_W-1:0];
      if (req_i[idx]) begin
        winner_o = idx;
        found    = 1'b1;
      end
    end
    fire_o  = en_i & found;
    grant_o = fire_o ? (N'(1) << winner_o) : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (fire_o) ptr_d = (winner_o == IDX_W'(N - 1)) ? '0 : winner_o + IDX_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!nrst) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/carrd_wb_arbiter.sv
// Writeback arbiter: round-robin selection of one vector result per cycle into
// a single output register that drives the register-file write port.
module carrd_wb_arbiter #(
  parameter int N_SRC = carrd_pkg::N_SRC,
  parameter int VD_W  = carrd_pkg::VD_W,
  parameter int EL_W  = carrd_pkg::EL_W
) (
  input  logic                                         clk,
  input  logic                                         nrst,
  input  logic [N_SRC-1:0]                             src_valid,
  output logic [N_SRC-1:0]                             src_ready,
  input  logic [N_SRC-1:0][VD_W-1:0]                   src_vd,
  input  logic [N_SRC-1:0][carrd_pkg::SRC_DATA_W-1:0]  src_data,
  input  logic [EL_W-1:0]                              red_el_idx,
  input  logic                                         rf_stall,
  input  logic                                         flush,
  output logic                                         reg_wr_en,
  output logic                                         el_wr_en,
  output logic [VD_W-1:0]                              reg_wr_addr,
  output logic [EL_W-1:0]                              el_wr_idx,
  output logic [carrd_pkg::LANE_W-1:0]                 reg_wr_data,
  output logic [carrd_pkg::LANE_W-1:0]                 reg_wr_data_2,
  output logic [carrd_pkg::LANE_W-1:0]                 reg_wr_data_3,
  output logic [carrd_pkg::LANE_W-1:0]                 reg_wr_data_4,
  output logic [2:0]                                   wb_src,
  output logic                                         busy,
  output logic [15:0]                                  stall_cnt
);

  import carrd_pkg::*;

  wb_state_e state_q, state_d;

  logic [VD_W-1:0]                   addr_q, addr_d;
  logic [EL_W-1:0]                   el_idx_q, el_idx_d;
  logic [N_LANES-1:0][LANE_W-1:0]    lanes_q, lanes_d;
  logic [SRC_IDX_W-1:0]              src_q, src_d;
  logic                              is_red_q, is_red_d;
  logic [CNT_W-1:0]                  stall_q, stall_d;

  logic                              can_accept;
  logic                              fire;
  logic [SRC_IDX_W-1:0]              winner;

  // A stalled or flushed output register cannot take a new winner; reset
  // also blocks every grant.
  assign can_accept = nrst && ((state_q == ST_IDLE) || (!rf_stall && !flush));

  carrd_rr_arb #(
    .N     (N_SRC),
    .IDX_W (SRC_IDX_W)
  ) u_rr_arb (
    .clk      (clk),
    .nrst     (nrst),
    .req_i    (src_valid),
    .en_i     (can_accept),
    .grant_o  (src_ready),
    .winner_o (winner),
    .fire_o   (fire)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (fire) state_d = ST_OUT;
      ST_OUT: begin
        if (flush)          state_d = ST_IDLE;
        else if (!rf_stall) state_d = fire ? ST_OUT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    el_idx_d = el_idx_q;
    lanes_d  = lanes_q;
    src_d    = src_q;
    is_red_d = is_red_q;
    if (fire) begin
      addr_d   = src_vd[winner];
      src_d    = winner;
      is_red_d = (winner == SRC_VRED);
      if (is_red_d) begin
        lanes_d    = '0;
        lanes_d[0] = {{(LANE_W-RED_W){1'b0}}, src_data[winner][RED_W-1:0]};
        el_idx_d   = red_el_idx;
      end else begin
        lanes_d  = src_data[winner];
        el_idx_d = '0;
      end
    end
  end

  always_comb begin
    stall_d = stall_q;
    if ((state_q == ST_OUT) && rf_stall && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + CNT_W'(1);
  end

  // NOTE: the datapath registers are reset too, because the cleared values
  // of the address, lanes and source index are visible at the ports.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      el_idx_q <= '0;
      lanes_q  <= '0;
      src_q    <= '0;
      is_red_q <= 1'b0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      el_idx_q <= el_idx_d;
      lanes_q  <= lanes_d;
      src_q    <= src_d;
      is_red_q <= is_red_d;
      stall_q  <= stall_d;
    end
  end

  assign busy          = (state_q == ST_OUT);
  assign reg_wr_en     = busy & ~is_red_q;
  assign el_wr_en      = busy &  is_red_q;
  assign reg_wr_addr   = addr_q;
  assign el_wr_idx     = el_idx_q;
  assign reg_wr_data   = lanes_q[0];
  assign reg_wr_data_2 = lanes_q[1];
  assign reg_wr_data_3 = lanes_q[2];
  assign reg_wr_data_4 = lanes_q[3];
  assign wb_src        = src_q;
  assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_carrd_wb_arbiter.sv
// Directed bench for carrd_wb_arbiter with a scoreboard of expected writes.
module tb_carrd_wb_arbiter;

  import carrd_pkg::*;

  logic                           clk = 1'b0;
  logic                           nrst;
  logic [N_SRC-1:0]               src_valid;
  logic [N_SRC-1:0]               src_ready;
  logic [N_SRC-1:0][VD_W-1:0]     src_vd;
  logic [N_SRC-1:0][SRC_DATA_W-1:0] src_data;
  logic [EL_W-1:0]                red_el_idx;
  logic                           rf_stall;
  logic                           flush;
  logic                           reg_wr_en;
  logic                           el_wr_en;
  logic [VD_W-1:0]                reg_wr_addr;
  logic [EL_W-1:0]                el_wr_idx;
  logic [LANE_W-1:0]              reg_wr_data;
  logic [LANE_W-1:0]              reg_wr_data_2;
  logic [LANE_W-1:0]              reg_wr_data_3;
  logic [LANE_W-1:0]              reg_wr_data_4;
  logic [2:0]                     wb_src;
  logic                           busy;
  logic [15:0]                    stall_cnt;

  carrd_wb_arbiter dut (
    .clk           (clk),
    .nrst          (nrst),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .src_vd        (src_vd),
    .src_data      (src_data),
    .red_el_idx    (red_el_idx),
    .rf_stall      (rf_stall),
    .flush         (flush),
    .reg_wr_en     (reg_wr_en),
    .el_wr_en      (el_wr_en),
    .reg_wr_addr   (reg_wr_addr),
    .el_wr_idx     (el_wr_idx),
    .reg_wr_data   (reg_wr_data),
    .reg_wr_data_2 (reg_wr_data_2),
    .reg_wr_data_3 (reg_wr_data_3),
    .reg_wr_data_4 (reg_wr_data_4),
    .wb_src        (wb_src),
    .busy          (busy),
    .stall_cnt     (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [VD_W-1:0]       vd;
    logic [SRC_DATA_W-1:0] lanes;
    logic                  red;
    logic [EL_W-1:0]       idx;
    logic [2:0]            src;
  } exp_t;

  exp_t exp_q[$];
  int   commit_log[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_ptr    = 0;
  bit   m_busy   = 1'b0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_src(input int i);
    for (int k = 0; k < SRC_DATA_W / 32; k++) src_data[i][k*32 +: 32] = $urandom();
    src_vd[i] = VD_W'($urandom());
  endtask

  function automatic exp_t mk_exp(input int w);
    exp_t                  e;
    logic [SRC_DATA_W-1:0] d;
    d     = src_data[w];
    e.vd  = src_vd[w];
    e.src = 3'(w);
    e.red = (w == 4);
    e.idx = red_el_idx;
    e.lanes = e.red ? {{(SRC_DATA_W-32){1'b0}}, d[31:0]} : d;
    return e;
  endfunction

  // One clock: compare the DUT against the model at the falling edge, advance
  // the model, then return just after the rising edge.
  task automatic tick();
    logic [N_SRC-1:0]      mg;
    logic [SRC_DATA_W-1:0] obs_lanes;
    int                    mw;
    bit                    acc;
    @(negedge clk);
    acc = nrst && (!m_busy || (!rf_stall && !flush));
    mg  = '0;
    mw  = -1;
    if (acc) begin
      for (int i = 0; i < N_SRC; i++) begin
        int j;
        j = (m_ptr + i) % N_SRC;
        if (mw < 0 && src_valid[j]) mw = j;
      end
    end
    if (mw >= 0) mg[mw] = 1'b1;
    check("src_ready", src_ready, mg);
    check("busy", busy, m_busy);
    if (m_busy) begin
      check("sb_nonempty", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        obs_lanes = {reg_wr_data_4, reg_wr_data_3, reg_wr_data_2, reg_wr_data};
        check("sb_addr", reg_wr_addr, exp_q[0].vd);
        check("sb_lanes", obs_lanes, exp_q[0].lanes);
        check("sb_reg_en", reg_wr_en, !exp_q[0].red);
        check("sb_el_en", el_wr_en, exp_q[0].red);
        check("sb_src", wb_src, exp_q[0].src);
        if (exp_q[0].red) check("sb_el_idx", el_wr_idx, exp_q[0].idx);
      end
    end else begin
      check("idle_strobes", {reg_wr_en, el_wr_en}, 2'b00);
    end
    if (!nrst) begin
      exp_q.delete();
      m_busy = 1'b0;
      m_ptr  = 0;
    end else begin
      if (m_busy && !flush && rf_stall) begin
        m_busy = 1'b1;
      end else begin
        if (m_busy && !flush) commit_log.push_back(int'(wb_src));
        if (m_busy && exp_q.size() > 0) void'(exp_q.pop_front());
        m_busy = 1'b0;
      end
      if (mw >= 0) begin
        exp_q.push_back(mk_exp(mw));
        m_busy = 1'b1;
        m_ptr  = (mw + 1) % N_SRC;
      end
    end
    @(posedge clk);
    #1;
    if (mw >= 0) rand_src(mw);
  endtask

  int fair_order[6] = '{0, 1, 2, 3, 4, 0};

  initial begin
    nrst       = 1'b0;
    src_valid  = '0;
    src_vd     = '0;
    src_data   = '0;
    red_el_idx = '0;
    rf_stall   = 1'b0;
    flush      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nrst = 1'b1;

    check("rst_busy", busy, 1'b0);
    check("rst_addr", reg_wr_addr, '0);
    check("rst_lanes", {reg_wr_data_4, reg_wr_data_3, reg_wr_data_2, reg_wr_data}, '0);
    check("rst_src", wb_src, '0);
    check("rst_stall_cnt", stall_cnt, '0);

    // Single VALU request.
    src_vd[0]   = 5'd3;
    src_data[0] = {128'hDDDD_0004, 128'hCCCC_0003, 128'hBBBB_0002, 128'hAAAA_0001};
    src_valid   = 5'b00001;
    #1;
    check("single_ready", src_ready, 5'b00001);
    tick();
    src_valid = '0;
    check("single_reg_en", reg_wr_en, 1'b1);
    check("single_addr", reg_wr_addr, 5'd3);
    check("single_lane0", reg_wr_data, 128'hAAAA_0001);
    check("single_lane3", reg_wr_data_4, 128'hDDDD_0004);
    tick();
    check("single_idle", {busy, reg_wr_en}, 2'b00);

    // Fairness from a freshly reset pointer.
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    for (int i = 0; i < N_SRC; i++) rand_src(i);
    src_valid = '1;
    commit_log.delete();
    repeat (6) begin
      tick();
      check("fair_strobe", reg_wr_en | el_wr_en, 1'b1);
    end
    src_valid = '0;
    tick();
    check("fair_len", commit_log.size(), 6);
    for (int i = 0; i < 6 && i < commit_log.size(); i++)
      check("fair_order", commit_log[i], fair_order[i]);
    tick();

    // Stall with VMUL in the output register and VLSU waiting.
    rand_src(1);
    rand_src(2);
    src_valid = 5'b00010;
    tick();
    src_valid = 5'b00100;
    rf_stall  = 1'b1;
    repeat (3) tick();
    check("stall_cnt", stall_cnt, 16'd3);
    check("stall_src", wb_src, 3'd1);
    check("stall_ready", src_ready, 5'b00000);
    rf_stall = 1'b0;
    #1;
    check("stall_release_ready", src_ready, 5'b00100);
    tick();
    check("stall_next_src", wb_src, 3'd2);
    src_valid = '0;
    repeat (2) tick();

    // Reduction element write.
    rand_src(4);
    src_vd[4]         = 5'd9;
    src_data[4][31:0] = 32'hDEAD_BEEF;
    red_el_idx        = 4'd7;
    src_valid         = 5'b10000;
    tick();
    src_valid = '0;
    check("red_el_en", el_wr_en, 1'b1);
    check("red_reg_en", reg_wr_en, 1'b0);
    check("red_lane0", reg_wr_data, 128'hDEAD_BEEF);
    check("red_upper", {reg_wr_data_4, reg_wr_data_3, reg_wr_data_2}, '0);
    check("red_idx", el_wr_idx, 4'd7);
    check("red_addr", reg_wr_addr, 5'd9);
    tick();

    // Flush in OUT, then flush in IDLE.
    rand_src(0);
    src_valid = 5'b00001;
    tick();
    src_valid = '0;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_strobes", {busy, reg_wr_en, el_wr_en}, 3'b000);
    src_valid = 5'b00011;
    #1;
    check("flush_ptr", src_ready, 5'b00010);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_idle_accept", {busy, wb_src}, {1'b1, 3'd1});
    src_valid = '0;
    repeat (2) tick();

    // Reset while the output register is occupied.
    rand_src(2);
    src_valid = 5'b00100;
    tick();
    src_valid = '1;
    nrst      = 1'b0;
    #1;
    check("rst_out_ready", src_ready, 5'b00000);
    tick();
    check("rst_out_clear", {busy, reg_wr_en, el_wr_en, wb_src, reg_wr_addr, el_wr_idx}, '0);
    check("rst_out_lanes", {reg_wr_data_4, reg_wr_data_3, reg_wr_data_2, reg_wr_data}, '0);
    check("rst_out_cnt", stall_cnt, 16'd0);
    nrst = 1'b1;
    #1;
    check("rst_grant0", src_ready, 5'b00001);
    tick();
    src_valid = '0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
